// File: rtl/mywcfifo_pkg.sv
// Shared constants and helpers for the width-down-converting FIFO.
package mywcfifo_pkg;

  // Slice-order encodings for the LSB_FIRST parameter.
  localparam int SLICE_MSB_FIRST = 0;
  localparam int SLICE_LSB_FIRST = 1;

  // Ceiling log2, usable in constant expressions; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mywcfifo_ram.sv
// Simple dual-port RAM for the FIFO: one write port, one registered read
// port. The slice selector travels with the read so the downstream mux
// lines up with the registered word.
module mywcfifo_ram
  import mywcfifo_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 256,
  parameter int SLICE_W = 1,
  localparam int AW     = clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic               re_i,
  input  logic [AW-1:0]      raddr_i,
  input  logic [SLICE_W-1:0] slice_i,
  output logic [WIDTH-1:0]   rdata_o,
  output logic [SLICE_W-1:0] slice_o
);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   rdata_q;
  logic [SLICE_W-1:0] slice_q;

  // Write port; storage is never cleared, stale words are simply unreachable.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read of the addressed word plus its slice selector; both hold when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      slice_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
      slice_q <= slice_i;
    end
  end

  assign rdata_o = rdata_q;
  assign slice_o = slice_q;

endmodule

// File: rtl/mywcfifo.sv
// Single-clock width-down-converting FIFO: wide words in, RATIO narrow
// slices out, with a single occupancy counter in read-word units.
module mywcfifo
  import mywcfifo_pkg::*;
#(
  parameter int WR_WIDTH  = 16,
  parameter int RATIO     = 2,
  parameter int WR_DEPTH  = 256,
  parameter int LSB_FIRST = 1,
  parameter int AF_LEVEL  = 240,
  parameter int AE_LEVEL  = 16,
  localparam int RD_W     = WR_WIDTH / RATIO,
  localparam int RD_DEPTH = WR_DEPTH * RATIO,
  localparam int WAW      = clog2(WR_DEPTH) + 1,
  localparam int RAW      = clog2(RD_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WR_WIDTH-1:0] data,
  input  logic                wrreq,
  input  logic                rdreq,
  output logic [RD_W-1:0]     q,
  output logic                rdempty,
  output logic                wrfull,
  output logic [RAW-1:0]      rdusedw,
  output logic [WAW-1:0]      wrusedw,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
);

  localparam int WPW = clog2(WR_DEPTH);
  localparam int RPW = clog2(RD_DEPTH);
  localparam int SW  = clog2(RATIO);

  logic [WPW-1:0] wptr_q, wptr_d;
  logic [RPW-1:0] rptr_q, rptr_d;
  logic [RAW-1:0] cnt_q, cnt_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;

  logic           wr_ok;
  logic           rd_ok;
  logic [RAW-1:0] wr_round;
  logic [SW-1:0]  rd_slice;
  logic [SW-1:0]  rd_slice_dly;
  logic [WR_WIDTH-1:0] rd_word;
  logic [RATIO-1:0][RD_W-1:0] word_slices;

  // Flags come straight from the registered count.
  assign rdempty      = (cnt_q == '0);
  assign wrfull       = (int'(cnt_q) > (RD_DEPTH - RATIO));
  assign rdusedw      = cnt_q;
  assign wr_round     = cnt_q + RAW'(RATIO - 1);
  assign wrusedw      = WAW'(wr_round >> SW);
  assign almost_full  = (int'(wrusedw) >= AF_LEVEL);
  assign almost_empty = (int'(cnt_q) <= AE_LEVEL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Requests are judged independently against pre-edge occupancy.
  assign wr_ok = wrreq & ~wrfull;
  assign rd_ok = rdreq & ~rdempty;

  // Low read-pointer bits pick the slice; MSB-first order just inverts them.
  assign rd_slice = (LSB_FIRST == SLICE_LSB_FIRST) ? rptr_q[SW-1:0] : ~rptr_q[SW-1:0];

  // Next-state for pointers, occupancy and the error pulses.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    overflow_d  = wrreq & wrfull;
    underflow_d = rdreq & rdempty;
    if (wr_ok) begin
      wptr_d = wptr_q + WPW'(1);
    end
    if (rd_ok) begin
      rptr_d = rptr_q + RPW'(1);
    end
    case ({wr_ok, rd_ok})
      2'b11:   cnt_d = cnt_q + RAW'(RATIO - 1);
      2'b10:   cnt_d = cnt_q + RAW'(RATIO);
      2'b01:   cnt_d = cnt_q - RAW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register; reset discards everything, including a half-read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  mywcfifo_ram #(
    .WIDTH   (WR_WIDTH),
    .DEPTH   (WR_DEPTH),
    .SLICE_W (SW)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_ok),
    .waddr_i (wptr_q),
    .wdata_i (data),
    .re_i    (rd_ok),
    .raddr_i (rptr_q[RPW-1:SW]),
    .slice_i (rd_slice),
    .rdata_o (rd_word),
    .slice_o (rd_slice_dly)
  );

  assign word_slices = rd_word;
  assign q           = word_slices[rd_slice_dly];

endmodule

// File: tb/tb_mywcfifo.sv
// Directed self-checking bench for mywcfifo: default LSB-first instance
// plus an MSB-first instance sharing the same stimulus.
module tb_mywcfifo;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic        wrreq;
  logic        rdreq;

  logic [7:0]  qL, qM;
  logic        rdemptyL, rdemptyM;
  logic        wrfullL, wrfullM;
  logic [9:0]  rdusedwL, rdusedwM;
  logic [8:0]  wrusedwL, wrusedwM;
  logic        afL, afM;
  logic        aeL, aeM;
  logic        ovfL, ovfM;
  logic        unfL, unfM;

  int testsRun;
  int testsFailed;

  mywcfifo dutL (
    .clk          (clk),
    .rst          (rst),
    .data         (data),
    .wrreq        (wrreq),
    .rdreq        (rdreq),
    .q            (qL),
    .rdempty      (rdemptyL),
    .wrfull       (wrfullL),
    .rdusedw      (rdusedwL),
    .wrusedw      (wrusedwL),
    .almost_full  (afL),
    .almost_empty (aeL),
    .overflow     (ovfL),
    .underflow    (unfL)
  );

  mywcfifo #(.LSB_FIRST(0)) dutM (
    .clk          (clk),
    .rst          (rst),
    .data         (data),
    .wrreq        (wrreq),
    .rdreq        (rdreq),
    .q            (qM),
    .rdempty      (rdemptyM),
    .wrfull       (wrfullM),
    .rdusedw      (rdusedwM),
    .wrusedw      (wrusedwM),
    .almost_full  (afM),
    .almost_empty (aeM),
    .overflow     (ovfM),
    .underflow    (unfM)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic wr, input logic rd, input logic [15:0] d);
    rst   = r;
    wrreq = wr;
    rdreq = rd;
    data  = d;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    logic [7:0] expL;
    logic [7:0] expM;
    testsRun    = 0;
    testsFailed = 0;
    rst   = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    data  = '0;
    @(negedge clk);

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("rst_rdusedw", rdusedwL, 0);
    checkOutput("rst_wrusedw", wrusedwL, 0);
    checkOutput("rst_rdempty", rdemptyL, 1);
    checkOutput("rst_wrfull", wrfullL, 0);
    checkOutput("rst_ae", aeL, 1);
    checkOutput("rst_af", afL, 0);
    checkOutput("rst_q", qL, 0);
    checkOutput("rst_ovf", ovfL, 0);
    checkOutput("rst_unf", unfL, 0);

    // Scenario 1: one word, two reads
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0400);
    checkOutput("s1_rdusedw_2", rdusedwL, 2);
    checkOutput("s1_wrusedw_1", wrusedwL, 1);
    checkOutput("s1_rdempty_0", rdemptyL, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s1_rdusedw_1", rdusedwL, 1);
    checkOutput("s1_wrusedw_1b", wrusedwL, 1);
    checkOutput("s1_q0", qL, 8'h00);
    checkOutput("s1_q0_msb", qM, 8'h04);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s1_rdusedw_0", rdusedwL, 0);
    checkOutput("s1_wrusedw_0", wrusedwL, 0);
    checkOutput("s1_q1", qL, 8'h04);
    checkOutput("s1_q1_msb", qM, 8'h00);
    checkOutput("s1_rdempty_1", rdemptyL, 1);

    // Scenario 2: fill to full, overflow, then drain two slices
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'(16'h0400 + i));
      if (i == 238) checkOutput("s2_af_239", afL, 0);
      if (i == 239) checkOutput("s2_af_240", afL, 1);
      if (i == 254) checkOutput("s2_wrfull_255", wrfullL, 0);
    end
    checkOutput("s2_wrfull", wrfullL, 1);
    checkOutput("s2_rdusedw_512", rdusedwL, 512);
    checkOutput("s2_wrusedw_256", wrusedwL, 256);
    checkOutput("s2_ovf_before", ovfL, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hDEAD);
    checkOutput("s2_ovf", ovfL, 1);
    checkOutput("s2_cnt_sat", rdusedwL, 512);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("s2_ovf_pulse", ovfL, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s2_rdusedw_511", rdusedwL, 511);
    checkOutput("s2_wrusedw_256b", wrusedwL, 256);
    checkOutput("s2_wrfull_still", wrfullL, 1);
    checkOutput("s2_q_first", qL, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s2_wrfull_clear", wrfullL, 0);
    checkOutput("s2_rdusedw_510", rdusedwL, 510);
    checkOutput("s2_q_second", qL, 8'h04);

    // Scenario 3: 255 words, read all 510 slices
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 255; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'(16'h0400 + i));
    end
    checkOutput("s3_rdusedw_510", rdusedwL, 510);
    for (int j = 0; j < 510; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
      expL = (j % 2 == 0) ? 8'(j / 2) : 8'h04;
      expM = (j % 2 == 0) ? 8'h04 : 8'(j / 2);
      checkOutput($sformatf("s3_q_%0d", j), qL, expL);
      checkOutput($sformatf("s3_qm_%0d", j), qM, expM);
      checkOutput($sformatf("s3_ae_%0d", j), aeL, ((509 - j) <= 16) ? 1 : 0);
    end
    checkOutput("s3_rdempty", rdemptyL, 1);

    // Scenario 4: simultaneous write and read with cnt=3
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1122);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h3344);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s4_cnt3", rdusedwL, 3);
    checkOutput("s4_q_a", qL, 8'h22);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h5566);
    checkOutput("s4_cnt4", rdusedwL, 4);
    checkOutput("s4_q_b", qL, 8'h11);
    checkOutput("s4_q_b_msb", qM, 8'h22);
    checkOutput("s4_no_ovf", ovfL, 0);
    checkOutput("s4_no_unf", unfL, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s4_q_c", qL, 8'h44);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s4_q_d", qL, 8'h33);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s4_q_e", qL, 8'h66);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s4_q_f", qL, 8'h55);
    checkOutput("s4_empty", rdemptyL, 1);

    // Scenario 5: read on empty with a simultaneous write
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hABCD);
    checkOutput("s5_unf", unfL, 1);
    checkOutput("s5_rdusedw_2", rdusedwL, 2);
    checkOutput("s5_q_hold", qL, 8'h55);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s5_unf_pulse", unfL, 0);
    checkOutput("s5_q_cd", qL, 8'hCD);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s5_q_ab", qL, 8'hAB);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s5_unf_again1", unfL, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s5_unf_again2", unfL, 1);
    checkOutput("s5_q_hold2", qL, 8'hAB);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("s5_unf_drop", unfL, 0);

    // Scenario 6: reset mid-stream overrides a pending write
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'(16'h0500 + i));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    end
    checkOutput("s6_pre_cnt", rdusedwL, 17);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hFFFF);
    checkOutput("s6_rdusedw", rdusedwL, 0);
    checkOutput("s6_wrusedw", wrusedwL, 0);
    checkOutput("s6_rdempty", rdemptyL, 1);
    checkOutput("s6_q", qL, 0);
    checkOutput("s6_q_msb", qM, 0);
    checkOutput("s6_rdusedw_msb", rdusedwM, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1234);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s6_q_lo", qL, 8'h34);
    checkOutput("s6_qm_hi", qM, 8'h12);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("s6_q_hi", qL, 8'h12);
    checkOutput("s6_qm_lo", qM, 8'h34);
    checkOutput("s6_empty_msb", rdemptyM, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mywcfifo.md
Name: mywcfifo

Overview:
Single-clock, parametrised width-down-converting FIFO. It accepts WR_WIDTH-bit words and returns them as RATIO narrower read words of WR_WIDTH/RATIO bits each. It is the successor to the team's fixed 16-to-8 FIFO and adds:
- generic width, ratio and depth;
- selectable slice order;
- almost-full and almost-empty thresholds;
- overflow and underflow error pulses;
- full-range occupancy counts.

It sits between a wide producer (e.g. a sample packer) and a narrow consumer (e.g. a byte-serial link) in the same clock domain.

Parameters:
- WR_WIDTH, 16, write word width; must be divisible by RATIO.
- RATIO, 2, read words per write word; power of 2, at least 2.
- WR_DEPTH, 256, capacity in write words; power of 2, at least 4.
- LSB_FIRST, 1, 1: the first read of a word returns data[RD_W-1:0]; 0: the first read returns the MS slice.
- AF_LEVEL, 240, almost_full asserts when wrusedw >= AF_LEVEL.
- AE_LEVEL, 16, almost_empty asserts when rdusedw <= AE_LEVEL.
- Derived values: RD_W = WR_WIDTH/RATIO; RD_DEPTH = WR_DEPTH*RATIO; WAW = clog2(WR_DEPTH)+1; RAW = clog2(RD_DEPTH)+1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data  in  WR_WIDTH  write data.
- wrreq  in  1  write request.
- rdreq  in  1  read request.
- q  out  RD_W  read data, registered.
- rdempty  out  1  rdusedw == 0.
- wrfull  out  1  wrusedw == WR_DEPTH.
- rdusedw  out  RAW  stored read words, 0..RD_DEPTH.
- wrusedw  out  WAW  ceil(rdusedw/RATIO), 0..WR_DEPTH.
- almost_full  out  1  wrusedw >= AF_LEVEL.
- almost_empty  out  1  rdusedw <= AE_LEVEL.
- overflow  out  1  one-cycle pulse for a rejected write.
- underflow  out  1  one-cycle pulse for a rejected read.

Behaviour:
- Single occupancy counter cnt (RAW bits, read-word units). rdusedw = cnt; wrusedw = (cnt + RATIO-1) >> clog2(RATIO).
- All flags are combinational functions of the registered cnt, so they update the cycle after the causing edge. No ports are forced.
- Write acceptance: wr_ok = wrreq & ~wrfull, evaluated on pre-edge state.
  - Stores data at mem[wptr] and increments wptr (clog2(WR_DEPTH) bits, wraps naturally).
  - wrfull is defined as cnt > RD_DEPTH-RATIO. The write is refused while any partial slot remains unread.
- Read acceptance: rd_ok = rdreq & ~rdempty, evaluated on pre-edge state.
  - rptr (clog2(RD_DEPTH) bits) upper bits select the word; lower clog2(RATIO) bits select the slice.
  - Slice index k = rptr[low] if LSB_FIRST, else RATIO-1-rptr[low].
  - q <= mem[rptr_hi][k*RD_W +: RD_W] at the edge where rd_ok; 1-cycle latency (normal, non-show-ahead mode).
  - q holds its value when there is no accepted read.
- Same-cycle events: both requests are judged independently on pre-edge state.
  - Both accepted: cnt += RATIO-1.
  - Write only: cnt += RATIO.
  - Read only: cnt -= 1.
- Empty with wrreq and rdreq together: write accepted, read rejected, underflow=1. The data is readable from the next cycle.
- Full with wrreq and rdreq together: read accepted, write rejected, overflow=1. No write-through.
- overflow and underflow are registered, asserted for exactly the cycle after the rejected request, and re-asserted each cycle a rejected request persists.
- Pointer wrap: wptr wraps at WR_DEPTH, rptr at RD_DEPTH. cnt never wraps; it saturates logically by construction.
- Reset (sync, rst=1 at an edge):
  - wptr, rptr, cnt, q, overflow and underflow go to 0.
  - Resulting outputs: rdempty=1, wrfull=0, almost_empty=1, almost_full=(AF_LEVEL==0).
  - rst overrides simultaneous requests. Memory contents are not cleared; old data is unreachable.
- Reset mid-operation discards all stored words, including a partially read word.

Decomposition:
- Package mywcfifo_pkg:
  - clog2 constant function;
  - slice-order encodings LSB_FIRST/MSB_FIRST as localparams.
- Sub-module mywcfifo_ram:
  - simple dual-port RAM, WR_DEPTH x WR_WIDTH;
  - one write port, one registered read port.
  - The slice index is delayed one cycle alongside the read address so the mux after the RAM aligns with its output.
- Control logic (pointers, cnt, flags, error pulses) stays in the top level.

Test Plan:
All scenarios use default parameters.
1. Reset, then one write of 0x0400, then two reads → rdusedw 2→1→0; wrusedw 1→1→0; q=0x00 then 0x04; rdempty=1 at the end.
2. Write 256 words 0x0400+i → wrfull=1, rdusedw=512, almost_full set from wrusedw=240. A 257th write gives overflow=1 for one cycle, and cnt stays 512. Then one read → rdusedw=511, wrusedw=256, wrfull still 1. A second read → wrfull=0.
3. Read all 510 words after writing 255 words 0x0400+i → q sequence 0x00,0x04,0x01,0x04,…,0xFE,0x04; almost_empty rises when rdusedw=16.
4. With cnt=3, assert wrreq and rdreq together for one cycle → cnt=4, and q takes the expected slice.
5. Assert rdreq on an empty FIFO together with a write of 0xABCD → underflow=1, rdusedw=2, q unchanged. The next two reads return 0xCD then 0xAB.
6. After 10 writes and 3 reads, assert rst mid-stream → all counts 0, rdempty=1, q=0. A new write of 0x1234 then reads back 0x34, 0x12. Repeat with LSB_FIRST=0 → 0x12, 0x34.
